// File: rtl/sdpram_pkg.sv
// Shared definitions for the byte-enable simple dual-port RAM family.
package sdpram_pkg;

  localparam int unsigned MIN_READ_LATENCY = 1;
  localparam int unsigned MAX_READ_LATENCY = 3;

  // Number of independently writable lanes in a word.
  function automatic int unsigned num_bytes(input int unsigned data_width,
                                            input int unsigned byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/sdpram_byte_merge.sv
// Combinational per-byte merge: lanes with i_we set take i_new_word,
// all other lanes pass i_old_word through unchanged.
module sdpram_byte_merge
  import sdpram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]            i_old_word,
  input  logic [DATA_WIDTH-1:0]            i_new_word,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_we,
  output logic [DATA_WIDTH-1:0]            o_merged
);

  localparam int unsigned NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);

  // Start from the old word and overlay each enabled lane.
  always_comb begin
    o_merged = i_old_word;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (i_we[i]) begin
        o_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = i_new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/sdpram_be_pipe.sv
// Simple dual-port RAM: one byte-enabled write port, one read port with a
// registered read pipeline of READ_LATENCY stages, selectable
// read-during-write behaviour and a read-valid / collision strobe.
module sdpram_be_pipe
  import sdpram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned READ_LATENCY  = 1,
  parameter bit          RDW_NEW_DATA  = 1'b0,
  parameter bit          CLEAR_ON_IDLE = 1'b1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [ADDR_WIDTH-1:0]           addra,
  input  logic [DATA_WIDTH-1:0]           dina,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
  input  logic                            ena,
  input  logic [ADDR_WIDTH-1:0]           addrb,
  input  logic                            enb,
  output logic [DATA_WIDTH-1:0]           doutb,
  output logic                            doutb_valid,
  output logic                            rd_collision
);

  localparam int unsigned NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0 ||
      READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_param_check
    $fatal(1, "sdpram_be_pipe: illegal DATA_WIDTH/BYTE_WIDTH/READ_LATENCY combination");
  end

  typedef struct packed {
    logic                  valid;
    logic                  coll;
    logic [DATA_WIDTH-1:0] data;
  } rd_stage_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [DATA_WIDTH-1:0] w_old_word;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_hit;
  rd_stage_t             w_stage_in [READ_LATENCY];
  rd_stage_t             w_last;

  // Byte-lane writes; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (ena) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (wea[i]) begin
          r_mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign w_old_word = r_mem[addrb];
  assign w_hit      = ena & (|wea) & (addra == addrb);

  if (RDW_NEW_DATA) begin : g_rdw_new
    logic [NUM_BYTES-1:0] w_hit_we;
    assign w_hit_we = wea & {NUM_BYTES{w_hit}};
    sdpram_byte_merge #(
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH)
    ) u_merge (
      .i_old_word (w_old_word),
      .i_new_word (dina),
      .i_we       (w_hit_we),
      .o_merged   (w_rd_word)
    );
  end else begin : g_rdw_old
    assign w_rd_word = w_old_word;
  end

  assign w_stage_in[0] = '{valid: enb, coll: enb & w_hit, data: w_rd_word};

  for (genvar k = 0; k < READ_LATENCY; k++) begin : g_stage
    rd_stage_t r_q;

    if (k > 0) begin : g_link
      assign w_stage_in[k] = g_stage[k-1].r_q;
    end

    // Stage register: valid/coll always advance; data loads zero on idle
    // when clearing, otherwise only on a valid read so it holds last data.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_q <= '0;
      end else begin
        r_q.valid <= w_stage_in[k].valid;
        r_q.coll  <= w_stage_in[k].coll;
        if (w_stage_in[k].valid) begin
          r_q.data <= w_stage_in[k].data;
        end else if (CLEAR_ON_IDLE) begin
          r_q.data <= '0;
        end
      end
    end
  end

  assign w_last       = g_stage[READ_LATENCY-1].r_q;
  assign doutb        = (CLEAR_ON_IDLE && !w_last.valid) ? '0 : w_last.data;
  assign doutb_valid  = w_last.valid;
  assign rd_collision = w_last.valid & w_last.coll;

endmodule

// File: tb/tb_sdpram_be_pipe.sv
// Bench for sdpram_be_pipe: three parameter variants share one stimulus
// stream and are checked against a word-level memory model with a
// per-variant list of expected read returns.
module tb_sdpram_be_pipe;

  logic        clk;
  logic        resetn;
  logic [3:0]  addra;
  logic [31:0] dina;
  logic [3:0]  wea;
  logic        ena;
  logic [3:0]  addrb;
  logic        enb;
  logic [31:0] doutb [3];
  logic        dv    [3];
  logic        rc    [3];

  int checks = 0;
  int errors = 0;

  // Variant 0: L=1 old-data clear; 1: L=3 new-data hold; 2: L=2 new-data clear.
  sdpram_be_pipe #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1),
                   .RDW_NEW_DATA(1'b0), .CLEAR_ON_IDLE(1'b1)) u_d0 (
    .clk(clk), .resetn(resetn), .addra(addra), .dina(dina), .wea(wea), .ena(ena),
    .addrb(addrb), .enb(enb), .doutb(doutb[0]), .doutb_valid(dv[0]), .rd_collision(rc[0]));
  sdpram_be_pipe #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(3),
                   .RDW_NEW_DATA(1'b1), .CLEAR_ON_IDLE(1'b0)) u_d1 (
    .clk(clk), .resetn(resetn), .addra(addra), .dina(dina), .wea(wea), .ena(ena),
    .addrb(addrb), .enb(enb), .doutb(doutb[1]), .doutb_valid(dv[1]), .rd_collision(rc[1]));
  sdpram_be_pipe #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(2),
                   .RDW_NEW_DATA(1'b1), .CLEAR_ON_IDLE(1'b1)) u_d2 (
    .clk(clk), .resetn(resetn), .addra(addra), .dina(dina), .wea(wea), .ena(ena),
    .addrb(addrb), .enb(enb), .doutb(doutb[2]), .doutb_valid(dv[2]), .rd_collision(rc[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    int          due;
    logic [31:0] data;
    logic        coll;
  } exp_t;

  logic [31:0] mdl_mem [16];
  exp_t        q [$];
  logic [31:0] last [3];
  int          edge_n = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 2;
  endfunction
  function automatic bit rdw_new(input int d);
    return (d != 0);
  endfunction
  function automatic bit clr_idle(input int d);
    return (d != 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      logic        hv;
      logic [31:0] hd;
      logic        hc;
      hv = 1'b0; hd = '0; hc = 1'b0;
      foreach (q[i]) begin
        if (q[i].idx == d && q[i].due == edge_n) begin
          hv = 1'b1; hd = q[i].data; hc = q[i].coll;
        end
      end
      if (hv) last[d] = hd;
      else    hd = clr_idle(d) ? 32'h0 : last[d];
      chk($sformatf("d%0d_valid@%0d", d, edge_n), {31'b0, dv[d]}, {31'b0, hv});
      chk($sformatf("d%0d_data@%0d", d, edge_n), doutb[d], hd);
      chk($sformatf("d%0d_coll@%0d", d, edge_n), {31'b0, rc[d]}, {31'b0, hc});
    end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= edge_n) q.delete(i);
    end
  endtask

  // One clock: drive inputs, predict, clock, check; returns at the next negedge.
  task automatic step(input logic a_en, input logic [3:0] a_we, input logic [3:0] a_addr,
                      input logic [31:0] a_din, input logic b_en, input logic [3:0] b_addr);
    logic [31:0] old_w, new_w;
    logic        coll;
    ena = a_en; wea = a_we; addra = a_addr; dina = a_din; enb = b_en; addrb = b_addr;
    if (b_en) begin
      old_w = mdl_mem[b_addr];
      coll  = a_en && (a_we != 4'h0) && (a_addr == b_addr);
      new_w = old_w;
      if (coll) begin
        for (int b = 0; b < 4; b++) if (a_we[b]) new_w[b*8 +: 8] = a_din[b*8 +: 8];
      end
      for (int d = 0; d < 3; d++) begin
        q.push_back('{idx: d, due: edge_n + lat(d), data: rdw_new(d) ? new_w : old_w, coll: coll});
      end
    end
    if (a_en) begin
      for (int b = 0; b < 4; b++) if (a_we[b]) mdl_mem[a_addr][b*8 +: 8] = a_din[b*8 +: 8];
    end
    @(posedge clk);
    edge_n++;
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic reset_zero_check(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_d%0d_dout", tag, d), doutb[d], 32'h0);
      chk($sformatf("%s_d%0d_valid", tag, d), {31'b0, dv[d]}, 32'h0);
      chk($sformatf("%s_d%0d_coll", tag, d), {31'b0, rc[d]}, 32'h0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    ena = 1'b0; wea = '0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;
    for (int d = 0; d < 3; d++) last[d] = '0;
    #1;
    reset_zero_check("por");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Known contents everywhere; addr 5 preloaded for the byte-enable case.
    for (int a = 0; a < 16; a++) step(1'b1, 4'hF, a[3:0], (a == 5) ? 32'h11223344 : 32'h0, 1'b0, 4'h0);

    // Full write then read at L=1.
    step(1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 4'h0);
    chk("l1_not_early", {31'b0, dv[0]}, 32'h0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
    chk("l1_data", doutb[0], 32'hDEADBEEF);
    chk("l1_valid", {31'b0, dv[0]}, 32'h1);
    chk("l1_nocoll", {31'b0, rc[0]}, 32'h0);
    idle(1);
    chk("l1_idle_clear", doutb[0], 32'h0);

    // Byte enables.
    step(1'b1, 4'b0101, 4'd5, 32'hAABBCCDD, 1'b0, 4'h0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5);
    chk("be_merge", doutb[0], 32'h11BB33DD);

    // Same-cycle collision at addr 7.
    step(1'b1, 4'hF, 4'd7, 32'hCAFEF00D, 1'b1, 4'd7);
    chk("coll_old_data", doutb[0], 32'h0);
    chk("coll_old_flag", {31'b0, rc[0]}, 32'h1);
    idle(1);
    chk("coll_new_l2", doutb[2], 32'hCAFEF00D);
    chk("coll_new_l2_flag", {31'b0, rc[2]}, 32'h1);
    idle(1);
    chk("coll_new_l3", doutb[1], 32'hCAFEF00D);
    chk("coll_new_l3_flag", {31'b0, rc[1]}, 32'h1);

    // Back-to-back reads at L=3, with a late write to an in-flight address.
    step(1'b1, 4'hF, 4'd0, 32'hA0A0A0A0, 1'b0, 4'h0);
    step(1'b1, 4'hF, 4'd1, 32'hA1A1A1A1, 1'b0, 4'h0);
    step(1'b1, 4'hF, 4'd2, 32'hA2A2A2A2, 1'b0, 4'h0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd1);
    step(1'b1, 4'hF, 4'd1, 32'hFFFF0001, 1'b1, 4'd2);
    chk("l3_first", doutb[1], 32'hA0A0A0A0);
    idle(1);
    chk("l3_second_unaltered", doutb[1], 32'hA1A1A1A1);
    idle(1);
    chk("l3_third", doutb[1], 32'hA2A2A2A2);
    chk("l3_third_valid", {31'b0, dv[1]}, 32'h1);
    idle(1);
    chk("l3_done", {31'b0, dv[1]}, 32'h0);

    // Idle data behaviour.
    step(1'b1, 4'hF, 4'd9, 32'h5A5A5A5A, 1'b0, 4'h0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd9);
    chk("coi_read", doutb[0], 32'h5A5A5A5A);
    idle(1);
    chk("coi_clear", doutb[0], 32'h0);
    idle(4);
    chk("coi_hold", doutb[1], 32'h5A5A5A5A);
    chk("coi_hold_novalid", {31'b0, dv[1]}, 32'h0);

    // Reset with reads in flight: dropped, outputs cleared at once.
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
    resetn = 1'b0;
    #1;
    reset_zero_check("midrst");
    q.delete();
    for (int d = 0; d < 3; d++) last[d] = '0;
    @(negedge clk);
    idle(2);
    resetn = 1'b1;
    idle(1);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
    chk("persist_after_reset", doutb[0], 32'hDEADBEEF);
    idle(3);

    // Randomised traffic with frequent address collisions.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] aa, ab;
      aa = 4'($urandom_range(0, 15));
      ab = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), aa, $urandom(),
           ($urandom_range(0, 3) != 0), ab);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
